// File: rtl/voice_pkg.sv
// voice_pkg: shared constants, FSM state type and helpers for voice_allocator.
// Status nibbles, parameter-RAM word layout, phase-increment math.
package voice_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] PROG_CHG = 4'hC;

  localparam int GATE_BIT   = 43;
  localparam int NOTE_LSB   = 36;
  localparam int WAVE_LSB   = 32;
  localparam int DPHASE_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SEARCH,
    ST_WRITE
  } state_t;

  // Only ever called with elaboration constants; the real math folds away.
  function automatic logic [31:0] phase_delta(int n, int fs);
    real v_f;
    v_f = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    v_f = v_f * 4294967296.0 / real'(fs);
    return 32'(longint'(v_f));
  endfunction

  function automatic logic [43:0] pack_wdata(
    logic        gate,
    logic [6:0]  note,
    logic [3:0]  wave,
    logic [31:0] dphase
  );
    logic [43:0] v_d;
    v_d = '0;
    v_d[GATE_BIT] = gate;
    v_d[NOTE_LSB +: 7] = note;
    v_d[WAVE_LSB +: 4] = wave;
    v_d[DPHASE_LSB +: 32] = dphase;
    return v_d;
  endfunction

endpackage

// File: rtl/note_phase_rom.sv
// note_phase_rom: 128 x 32 MIDI-note to phase-increment table, registered output.
// Ports: clk, i_addr (note 0..127), o_data (delta_phase, valid 1 cycle after i_addr).
import voice_pkg::*;

module note_phase_rom #(
  parameter int FS_HZ = 48000
) (
  input  logic        clk,
  input  logic [6:0]  i_addr,
  output logic [31:0] o_data
);

  logic [31:0] w_rom [128];

  for (genvar g = 0; g < 128; g++) begin : g_rom
    assign w_rom[g] = phase_delta(g, FS_HZ);
  end

  always_ff @(posedge clk) begin
    o_data <= w_rom[i_addr];
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: MIDI note-on/off/program-change to voice parameter RAM writes.
// Ports: clk, reset (async, active-high); midi_byte_ready + midi_byte0..2 in;
// busy, midi_drop out; ram_we/ram_wr_ack handshake with ram_addr, ram_wdata.
// CHANNEL_FILTER_EN adds listen_channel and ignores other channels.
import voice_pkg::*;

module voice_allocator #(
  parameter int NUM_VOICES = 16,
  parameter int VOICE_W    = 4,
  parameter int FS_HZ      = 48000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               midi_byte_ready,
  input  logic [7:0]         midi_byte0,
  input  logic [7:0]         midi_byte1,
  input  logic [7:0]         midi_byte2,
`ifdef CHANNEL_FILTER_EN
  input  logic [3:0]         listen_channel,
`endif
  output logic               busy,
  output logic               midi_drop,
  output logic               ram_we,
  input  logic               ram_wr_ack,
  output logic [VOICE_W-1:0] ram_addr,
  output logic [43:0]        ram_wdata
);

  state_t              r_state;
  logic [3:0]          r_hi;
  logic [6:0]          r_key;
  logic [7:0]          r_vel;
  logic                r_is_on;
  logic [VOICE_W-1:0]  r_idx;
  logic [VOICE_W-1:0]  r_cnt;
  logic [VOICE_W-1:0]  r_voice;
  logic [VOICE_W-1:0]  r_rr;
  logic [3:0]          r_cur_wave;
  logic [43:0]         r_wdata;
  logic [NUM_VOICES-1:0] r_active;
  logic [6:0]          r_note [NUM_VOICES];
  logic [3:0]          r_wave [NUM_VOICES];

  logic [31:0] w_delta;
  logic        w_note_on;
  logic        w_note_off;
  logic        w_chan_ok;
  logic        w_free;
  logic        w_match;
  logic        w_last;

`ifdef CHANNEL_FILTER_EN
  logic [3:0] r_chan;
  logic       w_unused;
  assign w_unused  = midi_byte1[7];
  assign w_chan_ok = (r_chan == listen_channel);
`else
  logic w_unused;
  assign w_unused  = ^{midi_byte1[7], midi_byte0[3:0]};
  assign w_chan_ok = 1'b1;
`endif

  note_phase_rom #(
    .FS_HZ (FS_HZ)
  ) u_rom (
    .clk    (clk),
    .i_addr (r_key),
    .o_data (w_delta)
  );

  assign w_note_on  = (r_hi == NOTE_ON) && (r_vel != 8'd0);
  assign w_note_off = (r_hi == NOTE_OFF) ||
                      ((r_hi == NOTE_ON) && (r_vel == 8'd0));
  assign w_free  = !r_active[r_idx];
  assign w_match = r_active[r_idx] && (r_note[r_idx] == r_key);
  assign w_last  = (r_cnt == VOICE_W'(NUM_VOICES - 1));

  assign busy      = (r_state != ST_IDLE);
  assign midi_drop = midi_byte_ready && busy;
  assign ram_we    = (r_state == ST_WRITE);
  assign ram_addr  = r_voice;
  assign ram_wdata = r_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_key      <= '0;
      r_vel      <= '0;
      r_is_on    <= 1'b0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_voice    <= '0;
      r_rr       <= '0;
      r_cur_wave <= '0;
      r_wdata    <= '0;
      r_active   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_note[i] <= '0;
        r_wave[i] <= '0;
      end
`ifdef CHANNEL_FILTER_EN
      r_chan     <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (midi_byte_ready) begin
            r_hi    <= midi_byte0[7:4];
            r_key   <= midi_byte1[6:0];
            r_vel   <= midi_byte2;
`ifdef CHANNEL_FILTER_EN
            r_chan  <= midi_byte0[3:0];
`endif
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          r_cnt   <= '0;
          r_is_on <= w_note_on;
          r_idx   <= w_note_on ? r_rr : '0;
          if (!w_chan_ok) begin
            r_state <= ST_IDLE;
          end else if (w_note_on || w_note_off) begin
            r_state <= ST_SEARCH;
          end else begin
            if (r_hi == PROG_CHG) r_cur_wave <= r_key[3:0];
            r_state <= ST_IDLE;
          end
        end
        ST_SEARCH: begin
          r_idx <= r_idx + 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (r_is_on) begin
            // Full table after a whole lap: steal the round-robin slot.
            if (w_free || w_last) begin
              r_voice <= w_free ? r_idx : r_rr;
              r_wdata <= pack_wdata(1'b1, r_key, r_cur_wave, w_delta);
              r_state <= ST_WRITE;
            end
          end else if (w_match) begin
            r_voice <= r_idx;
            r_wdata <= pack_wdata(1'b0, r_note[r_idx], r_wave[r_idx],
                                  w_delta);
            r_state <= ST_WRITE;
          end else if (w_last) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (ram_wr_ack) begin
            r_active[r_voice] <= r_is_on;
            if (r_is_on) begin
              r_note[r_voice] <= r_key;
              r_wave[r_voice] <= r_cur_wave;
              r_rr            <= r_voice + 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: scoreboard bench for voice_allocator.
// A behavioural allocation model queues expected RAM writes per message.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        midi_byte_ready;
  logic [7:0]  midi_byte0;
  logic [7:0]  midi_byte1;
  logic [7:0]  midi_byte2;
  logic        busy;
  logic        midi_drop;
  logic        ram_we;
  logic        ram_wr_ack;
  logic [3:0]  ram_addr;
  logic [43:0] ram_wdata;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (16),
    .VOICE_W    (4),
    .FS_HZ      (48000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .midi_byte_ready (midi_byte_ready),
    .midi_byte0      (midi_byte0),
    .midi_byte1      (midi_byte1),
    .midi_byte2      (midi_byte2),
`ifdef CHANNEL_FILTER_EN
    .listen_channel  (4'h0),
`endif
    .busy            (busy),
    .midi_drop       (midi_drop),
    .ram_we          (ram_we),
    .ram_wr_ack      (ram_wr_ack),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata)
  );

  typedef struct {
    logic [3:0]  addr;
    logic [43:0] data;
  } wr_t;

  wr_t q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_writes = 0;

  bit         m_act [16];
  logic [6:0] m_note [16];
  logic [3:0] m_wave [16];
  int         m_rr;
  logic [3:0] m_cw;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_delta(int n);
    real f;
    f = 440.0 * (2.0 ** ((n - 69) / 12.0)) * 4294967296.0 / 48000.0;
    return 32'(longint'(f));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_act[i]  = 1'b0;
      m_note[i] = '0;
      m_wave[i] = '0;
    end
    m_rr = 0;
    m_cw = '0;
    q.delete();
  endtask

  task automatic model(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    logic [3:0] hi;
    int v;
    wr_t e;
    hi = b0[7:4];
    v = -1;
    if (hi == 4'h9 && b2 != 8'd0) begin
      for (int k = 0; k < 16; k++) begin
        int i;
        i = (m_rr + k) % 16;
        if (v < 0 && !m_act[i]) v = i;
      end
      if (v < 0) v = m_rr;
      e.addr = 4'(v);
      e.data = {1'b1, b1[6:0], m_cw, exp_delta(int'(b1[6:0]))};
      q.push_back(e);
      m_act[v] = 1'b1;
      m_note[v] = b1[6:0];
      m_wave[v] = m_cw;
      m_rr = (v + 1) % 16;
    end else if (hi == 4'h8 || hi == 4'h9) begin
      for (int k = 0; k < 16; k++)
        if (v < 0 && m_act[k] && m_note[k] == b1[6:0]) v = k;
      if (v >= 0) begin
        e.addr = 4'(v);
        e.data = {1'b0, m_note[v], m_wave[v], exp_delta(int'(b1[6:0]))};
        q.push_back(e);
        m_act[v] = 1'b0;
      end
    end else if (hi == 4'hC) begin
      m_cw = b1[3:0];
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ram_we && ram_wr_ack) begin
      wr_t e;
      n_writes++;
      if (q.size() == 0) begin
        check("unexp_write", {63'b0, ram_we}, 64'd0);
      end else begin
        e = q.pop_front();
        check("wr_addr", 64'(ram_addr), 64'(e.addr));
        check("wr_data", 64'(ram_wdata), 64'(e.data));
      end
    end
  end

  // Returns at the negedge where ram_we is first seen or busy has dropped.
  task automatic strobe(input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, output int lat);
    @(posedge clk);
    #1;
    midi_byte0 = b0;
    midi_byte1 = b1;
    midi_byte2 = b2;
    midi_byte_ready = 1'b1;
    model(b0, b1, b2);
    @(negedge clk);
    check("drop_idle", 64'(midi_drop), 64'd0);
    @(posedge clk);
    #1 midi_byte_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ram_we && busy && lat < 64);
    if (lat >= 64) check("strobe_timeout", 64'(busy), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic msg(input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2);
    int lat;
    strobe(b0, b1, b2, lat);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int wcount;
    logic [3:0]  sa;
    logic [43:0] sd;

    reset = 1'b1;
    midi_byte_ready = 1'b0;
    midi_byte0 = '0;
    midi_byte1 = '0;
    midi_byte2 = '0;
    ram_wr_ack = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(midi_drop), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_wdata", 64'(ram_wdata), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // First note-on: latency and the A440 table entry.
    strobe(8'h90, 8'h45, 8'h64, lat);
    check("lat_on", 64'(lat), 64'd3);
    check("a440_addr", 64'(ram_addr), 64'd0);
    check("a440_data", 64'(ram_wdata), 64'hC50_0258BF26);
    wait_idle();

    // Program change then note-on lands on voice 1 with wave 3.
    wcount = n_writes;
    msg(8'hC0, 8'h03, 8'h00);
    check("pc_nowrite", 64'(n_writes), 64'(wcount));
    strobe(8'h90, 8'h3C, 8'h40, lat);
    check("pc_addr", 64'(ram_addr), 64'd1);
    check("pc_wave", 64'(ram_wdata[35:32]), 64'd3);
    wait_idle();

    // Fill the table, then steal.
    for (int n = 0; n < 14; n++) msg(8'h90, 8'(70 + n), 8'h40);
    strobe(8'h90, 8'h5A, 8'h40, lat);
    check("lat_steal", 64'(lat), 64'd18);
    check("steal_addr", 64'(ram_addr), 64'd0);
    wait_idle();

    // Reset during a long search abandons the message.
    wcount = n_writes;
    @(posedge clk);
    #1;
    midi_byte0 = 8'h90;
    midi_byte1 = 8'h5B;
    midi_byte2 = 8'h40;
    midi_byte_ready = 1'b1;
    @(posedge clk);
    #1 midi_byte_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_we", 64'(ram_we), 64'd0);
    check("midrst_addr", 64'(ram_addr), 64'd0);
    check("midrst_wdata", 64'(ram_wdata), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_nowrite", 64'(n_writes), 64'(wcount));
    check("rst_we_low", 64'(ram_we), 64'd0);

    // Note-on/off pairs, velocity-0 release, unmatched release.
    strobe(8'h90, 8'h40, 8'h50, lat);
    check("post_rst_addr", 64'(ram_addr), 64'd0);
    wait_idle();
    strobe(8'h80, 8'h40, 8'h00, lat);
    check("off_gate", 64'(ram_wdata[43]), 64'd0);
    wait_idle();
    msg(8'h90, 8'h40, 8'h50);
    strobe(8'h90, 8'h40, 8'h00, lat);
    check("vel0_addr", 64'(ram_addr), 64'd1);
    wait_idle();
    wcount = n_writes;
    msg(8'h80, 8'h22, 8'h00);
    check("off_nomatch", 64'(n_writes), 64'(wcount));

    // Duplicate note-on takes a second voice.
    msg(8'h90, 8'h50, 8'h50);
    strobe(8'h90, 8'h50, 8'h50, lat);
    check("dup_addr", 64'(ram_addr), 64'd3);
    wait_idle();

    // Stalled ack: outputs hold, strobe during the wait is dropped.
    ram_wr_ack = 1'b0;
    strobe(8'h90, 8'h30, 8'h40, lat);
    check("stall_we", 64'(ram_we), 64'd1);
    sa = ram_addr;
    sd = ram_wdata;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        midi_byte0 = 8'h90;
        midi_byte1 = 8'h11;
        midi_byte2 = 8'h22;
        midi_byte_ready = 1'b1;
      end else begin
        midi_byte_ready = 1'b0;
      end
      @(negedge clk);
      check("hold_we", 64'(ram_we), 64'd1);
      check("hold_addr", 64'(ram_addr), 64'(sa));
      check("hold_data", 64'(ram_wdata), 64'(sd));
      check("drop_pulse", 64'(midi_drop), (i == 3) ? 64'd1 : 64'd0);
    end
    @(posedge clk);
    #1 ram_wr_ack = 1'b1;
    wait_idle();
    repeat (20) @(negedge clk);
    check("stall_done", 64'(ram_we), 64'd0);
    check("sb_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
